// File: rtl/neopx_axis_serializer.sv
// NeoPixel (WS2812/SK6812) serializer fed by an AXI-Stream pixel word.
// Latency: first line-high cycle is the cycle after the handshake; word time = bits * TBIT.
// Backpressure: tready only in IDLE (decoded from registered state); busy words are ignored.
module neopx_axis_serializer #(
   parameter int CLK_FREQ_HZ = 72_000_000,
   parameter int LED_TYPE    = 1,
   parameter int T0H_NS      = 400,
   parameter int T1H_NS      = 800,
   parameter int TBIT_NS     = 1250,
   parameter int RESET_US    = 80
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic        o_serial,
   output logic        o_busy
);

   // Tick counts, rounded to nearest; 64-bit math because the latch gap overflows 32 bits.
   localparam longint KHZ  = CLK_FREQ_HZ / 1000;
   localparam int     T0H  = int'((KHZ * T0H_NS + 500_000) / 1_000_000);
   localparam int     T1H  = int'((KHZ * T1H_NS + 500_000) / 1_000_000);
   localparam int     TBIT = int'((KHZ * TBIT_NS + 500_000) / 1_000_000);
   localparam int     RST  = int'((KHZ * (RESET_US * 1000) + 500_000) / 1_000_000);

   localparam int CNT_MAX = (TBIT > RST) ? TBIT : RST;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] T0H_C  = CW'(T0H);
   localparam logic [CW-1:0] T1H_C  = CW'(T1H);
   localparam logic [CW-1:0] LOW0_C = CW'(TBIT - T0H);
   localparam logic [CW-1:0] LOW1_C = CW'(TBIT - T1H);
   localparam logic [CW-1:0] RST_C  = CW'(RST);
   localparam logic [4:0]    MSB_IDX = (LED_TYPE == 0) ? 5'd23 : 5'd31;

   // Refuse to build with a clock or timing that cannot produce legal pulses.
   generate
      if (CLK_FREQ_HZ < 10_000_000 || CLK_FREQ_HZ > 200_000_000) begin : g_bad_clk
         $fatal(1, "neopx_axis_serializer: CLK_FREQ_HZ out of range");
      end
      if (T0H < 1) begin : g_bad_t0h
         $fatal(1, "neopx_axis_serializer: T0H rounds to zero cycles");
      end
      if (TBIT - T1H < 1) begin : g_bad_t1l
         $fatal(1, "neopx_axis_serializer: no low time left after a 1-bit");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

   state_t        state;
   state_t        nxt_state;
   logic [CW-1:0] cnt;        // cycles remaining in the current phase, including this one
   logic [4:0]    bit_idx;
   logic [31:0]   data;
   logic          last;
   logic          accept;
   logic          cnt_done;
   logic          cur_bit;
   logic          nxt_bit;    // bit whose HIGH phase starts on the next transition into HIGH
   logic          serial_d;

   assign accept   = (state == IDLE) && s_axis_tvalid;
   assign cnt_done = (cnt <= CW'(1));
   assign cur_bit  = data[bit_idx];
   assign nxt_bit  = (state == IDLE) ? s_axis_tdata[MSB_IDX] : data[bit_idx - 5'd1];

   // State register; reset parks in LATCH so the strip is latched before the first word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= LATCH;
      else          state <= nxt_state;
   end

   // Next-state decode.
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:  if (accept) nxt_state = HIGH;
         HIGH:  if (cnt_done) nxt_state = LOW;
         LOW:   if (cnt_done) begin
                   if (bit_idx != 5'd0) nxt_state = HIGH;
                   else if (last)       nxt_state = LATCH;
                   else                 nxt_state = IDLE;
                end
         LATCH: if (cnt_done) nxt_state = IDLE;
         default: nxt_state = LATCH;
      endcase
   end

   // Output decode; the line level is computed one cycle ahead and registered.
   always_comb begin
      s_axis_tready = (state == IDLE);
      o_busy        = (state != IDLE);
      serial_d      = (nxt_state == HIGH);
   end

   // Registered line output, forced low asynchronously by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_serial <= 1'b0;
      else          o_serial <= serial_d;
   end

   // Word capture, bit index and phase counter (loaded with the full phase length on entry).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt     <= RST_C;
         bit_idx <= 5'd0;
         data    <= 32'd0;
         last    <= 1'b0;
      end else begin
         if (accept) begin
            data    <= (LED_TYPE == 0) ? {8'h00, s_axis_tdata[23:0]} : s_axis_tdata;
            last    <= s_axis_tlast;
            bit_idx <= MSB_IDX;
         end else if (state == LOW && cnt_done && bit_idx != 5'd0) begin
            bit_idx <= bit_idx - 5'd1;
         end

         if (nxt_state != state) begin
            case (nxt_state)
               HIGH:    cnt <= nxt_bit ? T1H_C : T0H_C;
               LOW:     cnt <= cur_bit ? LOW1_C : LOW0_C;
               LATCH:   cnt <= RST_C;
               default: cnt <= '0;
            endcase
         end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_neopx_axis_serializer.sv
// Directed bench for neopx_axis_serializer at 72 MHz tick counts.
// Drives and samples on the falling clock edge; two instances cover both LED types.
// Expected waveforms are rebuilt from the transmitted word and hand-computed tick counts.
module tb_neopx_axis_serializer;

   localparam int T0H  = 29;
   localparam int T1H  = 58;
   localparam int TBIT = 90;
   localparam int RST  = 5760;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] tdata;
   logic        tlast;
   logic        tvalid0, tvalid1;
   logic        ready0, ready1, ser0, ser1, busy0, busy1;
   bit          sel;
   logic        ser, rdy, busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic cap [0:32*TBIT-1];

   always #5 clk = ~clk;

   neopx_axis_serializer #(.LED_TYPE(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid1), .s_axis_tlast(tlast),
      .s_axis_tready(ready1), .o_serial(ser1), .o_busy(busy1));

   neopx_axis_serializer #(.LED_TYPE(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid0), .s_axis_tlast(tlast),
      .s_axis_tready(ready0), .o_serial(ser0), .o_busy(busy0));

   assign ser  = sel ? ser1  : ser0;
   assign rdy  = sel ? ready1 : ready0;
   assign busy = sel ? busy1 : busy0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel) tvalid1 = v;
      else     tvalid0 = v;
   endtask

   function automatic int hi_in_slot(input int b);
      int h = 0;
      for (int p = 0; p < TBIT; p++) if (cap[b*TBIT + p] === 1'b1) h++;
      return h;
   endfunction

   // Present a word on a falling edge where tready is high, capture nbits bit slots,
   // decode each slot by its high time and compare the waveform against the ideal one.
   task automatic send_word(input logic [31:0] d, input logic l, input int nbits, input bit toggle,
                            output logic [31:0] dec, output int wave_bad, output int rdy_seen);
      dec = '0; wave_bad = 0; rdy_seen = 0;
      tdata = d; tlast = l; set_valid(1'b1);
      for (int k = 0; k < nbits*TBIT; k++) begin
         @(negedge clk);
         cap[k] = ser;
         if (rdy === 1'b1) rdy_seen++;
         if (toggle) begin
            tdata = {tdata[30:0], ~tdata[31]} ^ 32'h9E37_79B9;
            tlast = ~tlast;
            if (k == nbits*TBIT - 1) set_valid(1'b0);
         end else if (k == 0) begin
            set_valid(1'b0);
         end
      end
      for (int b = 0; b < nbits; b++) begin
         logic bv;
         bv = d[nbits-1-b];
         for (int p = 0; p < TBIT; p++)
            if (cap[b*TBIT + p] !== ((p < (bv ? T1H : T0H)) ? 1'b1 : 1'b0)) wave_bad++;
         dec[nbits-1-b] = (hi_in_slot(b) >= TBIT/2);
      end
   endtask

   // Count falling-edge samples with tready low until it rises; line must stay low and
   // busy must be the exact complement of tready. lows = -1 if the bound expires.
   task automatic wait_ready(output int lows, output int bad);
      lows = 0; bad = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (rdy === 1'b1) begin
            if (busy !== 1'b0 || ser !== 1'b0) bad++;
            return;
         end
         lows++;
         if (ser !== 1'b0 || busy !== 1'b1) bad++;
      end
      lows = -1;
   endtask

   logic [31:0] dec, d;
   int wb, rs, lows, bad, wb_acc, rs_acc, idle_bad;

   initial begin
      rst_n = 1'b0; tdata = '0; tlast = 1'b0; tvalid0 = 1'b0; tvalid1 = 1'b0; sel = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_serial", ser1, 1'b0);
      chk("rst_tready", ready1, 1'b0);
      chk("rst_busy", busy1, 1'b1);
      chk("rst_tready_t0", ready0, 1'b0);

      // Release: released on a falling edge, so the rise is seen on the sample after
      // the RST-th rising edge, i.e. after RST-1 low samples.
      rst_n = 1'b1;
      wait_ready(lows, bad);
      chk("boot_latch_edges", lows + 1, RST);
      chk("boot_latch_line", bad, 0);
      chk("boot_tready_t0", ready0, 1'b1);

      // SK6812 word 0x80000001 with tlast
      sel = 1'b1;
      send_word(32'h8000_0001, 1'b1, 32, 1'b0, dec, wb, rs);
      chk("w1_decoded", dec, 32'h8000_0001);
      chk("w1_waveform", wb, 0);
      chk("w1_no_ready", rs, 0);
      chk("w1_bit31_high", hi_in_slot(0), T1H);
      chk("w1_bit30_high", hi_in_slot(1), T0H);
      chk("w1_bit0_high", hi_in_slot(31), T1H);
      wait_ready(lows, bad);
      chk("w1_latch_len", lows, RST);
      chk("w1_latch_line", bad, 0);

      // WS2812 word: upper byte must be ignored, exactly 24 bits then latch
      sel = 1'b0;
      send_word(32'hFF00_00A5, 1'b1, 24, 1'b0, dec, wb, rs);
      chk("w24_decoded", dec, 32'h0000_00A5);
      chk("w24_waveform", wb, 0);
      wait_ready(lows, bad);
      chk("w24_latch_len", lows, RST);
      chk("w24_latch_line", bad, 0);

      // Eight back-to-back words, tlast on the eighth
      sel = 1'b1; wb_acc = 0; rs_acc = 0;
      for (int w = 1; w <= 8; w++) begin
         if (w > 1) @(negedge clk);
         chk($sformatf("burst_rdy_%0d", w), rdy, 1'b1);
         d = 32'h1111_1111 * w;
         send_word(d, (w == 8), 32, 1'b0, dec, wb, rs);
         chk($sformatf("burst_word_%0d", w), dec, d);
         wb_acc += wb; rs_acc += rs;
      end
      chk("burst_waveform", wb_acc, 0);
      chk("burst_single_hs", rs_acc, 0);
      wait_ready(lows, bad);
      chk("burst_latch_len", lows, RST);
      chk("burst_latch_line", bad, 0);

      // tvalid held and tdata/tlast scrambled every cycle while busy
      send_word(32'h1234_5678, 1'b0, 32, 1'b1, dec, wb, rs);
      chk("hold_decoded", dec, 32'h1234_5678);
      chk("hold_waveform", wb, 0);
      chk("hold_no_accept", rs, 0);
      @(negedge clk);
      chk("hold_idle_no_latch", rdy, 1'b1);
      idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ser !== 1'b0 || rdy !== 1'b1) idle_bad++;
      end
      chk("idle_stays_low", idle_bad, 0);

      // Reset during the HIGH phase of bit 12 (slot 19)
      tdata = 32'h0000_1000; tlast = 1'b0; tvalid1 = 1'b1;
      @(negedge clk);
      tvalid1 = 1'b0;
      repeat (19*TBIT + 10) @(negedge clk);
      chk("b12_high", ser1, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("b12_rst_serial", ser1, 1'b0);
      chk("b12_rst_tready", ready1, 1'b0);
      chk("b12_rst_busy", busy1, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_ready(lows, bad);
      chk("b12_relatch_edges", lows + 1, RST);
      chk("b12_relatch_line", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
